// File: rtl/lpm_pkg.sv
// lpm_pkg: shared state type, word geometry and iteration-counter sizing for the LPM lookup engine
package lpm_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} lpm_state_e;
  localparam int LPM_WIDTH = 704;
  localparam int LPM_DONE_BIT = 0;
  function automatic int lpm_iter_w(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction
endpackage

// File: rtl/lpm_engine_stats.sv
// lpm_engine_stats: free-running 32-bit lookup and memory-access counters, wrapping modulo 2^32
module lpm_engine_stats (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        inc_lookup,
  input  logic        inc_access,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_accesses
);
  logic [31:0] lookups_q, lookups_d, accesses_q, accesses_d;
  always_comb begin
    lookups_d = inc_lookup ? lookups_q + 32'd1 : lookups_q;
    accesses_d = inc_access ? accesses_q + 32'd1 : accesses_q;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      lookups_q <= '0;
      accesses_q <= '0;
    end else begin
      lookups_q <= lookups_d;
      accesses_q <= accesses_d;
    end
  assign stat_lookups = lookups_q;
  assign stat_accesses = accesses_q;
endmodule

// File: rtl/lpm_lookup_engine.sv
// lpm_lookup_engine: walks chained LPM memory reads until a DONE node or MAX_ITER; LPM_ENGINE_STATS_EN adds counters
module lpm_lookup_engine
  import lpm_pkg::*;
#(
  parameter int WIDTH    = LPM_WIDTH,
  parameter int MAX_ITER = 8,
  parameter int DONE_BIT = LPM_DONE_BIT
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             enter__ENA,
  input  logic [WIDTH-1:0] enter_v,
  output logic             enter__RDY,
  output logic             mem_req__ENA,
  output logic [WIDTH-1:0] mem_req_v,
  input  logic             mem_req__RDY,
  input  logic [WIDTH-1:0] mem_resValue,
  input  logic             mem_resValue__RDY,
  output logic             mem_resAccept__ENA,
  output logic             out__RDY,
  output logic [WIDTH-1:0] out_v,
  output logic             out_limit,
  input  logic             outAccept__ENA,
  output logic [31:0]      stat_lookups,
  output logic [31:0]      stat_accesses
);
  localparam int IW = lpm_iter_w(MAX_ITER);
  localparam logic [IW-1:0] ITER_MAX = IW'(MAX_ITER);
  lpm_state_e state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [IW-1:0] iter_q, iter_d;
  logic limit_q, limit_d;
  logic resp_done, at_max;
  assign resp_done = mem_resValue[DONE_BIT];
  assign at_max = iter_q == ITER_MAX;
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    iter_d = iter_q;
    limit_d = limit_q;
    case (state_q)
      IDLE: if (enter__ENA) begin
        state_d = ISSUE;
        cur_d = enter_v;
        iter_d = '0;
        limit_d = 1'b0;
      end
      ISSUE: if (mem_req__RDY) begin
        state_d = WAIT;
        iter_d = iter_q + 1'b1;
      end
      // iter already counts the request just answered, so the cap is checked here
      WAIT: if (mem_resValue__RDY) begin
        cur_d = mem_resValue;
        state_d = (resp_done || at_max) ? RESULT : ISSUE;
        limit_d = !resp_done && at_max;
      end
      RESULT: if (outAccept__ENA) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q <= IDLE;
      cur_q <= '0;
      iter_q <= '0;
      limit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      iter_q <= iter_d;
      limit_q <= limit_d;
    end
  assign enter__RDY = state_q == IDLE;
  assign mem_req__ENA = (state_q == ISSUE) && mem_req__RDY;
  assign mem_req_v = cur_q;
  assign mem_resAccept__ENA = (state_q == WAIT) && mem_resValue__RDY;
  assign out__RDY = state_q == RESULT;
  assign out_v = cur_q;
  assign out_limit = limit_q;
`ifdef LPM_ENGINE_STATS_EN
  lpm_engine_stats u_stats (
    .CLK          (CLK),
    .nRST         (nRST),
    .inc_lookup   ((state_q == RESULT) && outAccept__ENA),
    .inc_access   (mem_req__ENA),
    .stat_lookups (stat_lookups),
    .stat_accesses(stat_accesses)
  );
`else
  assign stat_lookups = '0;
  assign stat_accesses = '0;
`endif
endmodule
